// File: rtl/mag_sched_pkg.sv
// -----------------------------------------------------------------------------
// mag_sched_pkg
// Shared definitions for the time-shared magnitude-compare scheduler.
//   NREQ_DEF  default number of requesters
//   CMP_W     comparator operand width (fixed by the 3 x mag4 comparator)
//   cmp_res_t {gt, eq, lt} result code; CMP_RST is the post-reset result
// -----------------------------------------------------------------------------
package mag_sched_pkg;

  localparam int NREQ_DEF = 4;
  localparam int CMP_W    = 12;

  typedef logic [2:0] cmp_res_t;

  localparam cmp_res_t CMP_GT  = 3'b100;
  localparam cmp_res_t CMP_EQ  = 3'b010;
  localparam cmp_res_t CMP_LT  = 3'b001;
  localparam cmp_res_t CMP_RST = CMP_EQ;

  // Width of the round-robin pointer / requester index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_cmp12.sv
// -----------------------------------------------------------------------------
// mag4 / mag_cmp12
// The existing 12-bit unsigned magnitude comparator built from three cascaded
// 4-bit comparator stages. The least significant stage has its cascade inputs
// tied to "equal"; each higher nibble overrides the lower result whenever its
// own nibbles differ, so the MSB nibble has the final say.
//   a, b           in  12  operands
//   agb, aeb, alb  out 1   exactly one is set
// -----------------------------------------------------------------------------
module mag4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       gt_i,
  input  logic       eq_i,
  input  logic       lt_i,
  output logic       gt_o,
  output logic       eq_o,
  output logic       lt_o
);

  always_comb begin
    gt_o = gt_i;
    eq_o = eq_i;
    lt_o = lt_i;
    if (a > b) begin
      gt_o = 1'b1;
      eq_o = 1'b0;
      lt_o = 1'b0;
    end else if (a < b) begin
      gt_o = 1'b0;
      eq_o = 1'b0;
      lt_o = 1'b1;
    end
  end

endmodule

module mag_cmp12 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic        agb,
  output logic        aeb,
  output logic        alb
);

  logic gt0, eq0, lt0;
  logic gt1, eq1, lt1;

  mag4 u_n0 (
    .a(a[3:0]), .b(b[3:0]),
    .gt_i(1'b0), .eq_i(1'b1), .lt_i(1'b0),
    .gt_o(gt0), .eq_o(eq0), .lt_o(lt0)
  );

  mag4 u_n1 (
    .a(a[7:4]), .b(b[7:4]),
    .gt_i(gt0), .eq_i(eq0), .lt_i(lt0),
    .gt_o(gt1), .eq_o(eq1), .lt_o(lt1)
  );

  mag4 u_n2 (
    .a(a[11:8]), .b(b[11:8]),
    .gt_i(gt1), .eq_i(eq1), .lt_i(lt1),
    .gt_o(agb), .eq_o(aeb), .lt_o(alb)
  );

endmodule

// File: rtl/mag_rr_pick.sv
// -----------------------------------------------------------------------------
// mag_rr_pick
// Combinational round-robin picker. Searches elig starting at index rr and
// wrapping modulo NREQ; the first set bit wins.
//   elig     in  NREQ  eligible requesters
//   rr       in  RR_W  highest-priority index for this search
//   win_oh   out NREQ  one-hot winner (zero when nothing eligible)
//   win_idx  out RR_W  binary index of the winner
//   win_any  out 1     a winner exists
// -----------------------------------------------------------------------------
module mag_rr_pick #(
  parameter int NREQ = 4,
  parameter int RR_W = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [RR_W-1:0] rr,
  output logic [NREQ-1:0] win_oh,
  output logic [RR_W-1:0] win_idx,
  output logic            win_any
);

  always_comb begin
    int              idx;
    logic [RR_W-1:0] idx_v;
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    idx     = 0;
    idx_v   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx   = (int'(rr) + k) % NREQ;
      idx_v = RR_W'(idx);
      if (!win_any && elig[idx_v]) begin
        win_any       = 1'b1;
        win_oh[idx_v] = 1'b1;
        win_idx       = idx_v;
      end
    end
  end

endmodule

// File: rtl/mag_sched.sv
// -----------------------------------------------------------------------------
// mag_sched
// Time-shares one 12-bit magnitude comparator among NREQ requesters.
//
// Timing: in grant cycle T the winner's gnt bit is asserted combinationally
// and its operands are captured at the end of T (so they only need to be
// stable during T). During T+1 the comparator evaluates the captured
// operands; the result and the owner's ack pulse are registered at the end of
// T+1 and are visible for one cycle. A requester is not eligible while its own
// compare sits in the operand stage, so it can be re-granted at the earliest
// in its ack cycle.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   req   [NREQ]   level requests, held until granted
//   a_in, b_in     packed operands, requester i at [i*12 +: 12]
//   gnt   [NREQ]   one-hot grant pulse (operands captured this cycle)
//   ack   [NREQ]   one-hot result-valid pulse
//   agb/aeb/alb    registered result, held while ack is zero
//   busy           a compare is in the operand stage or being acked
//
// Build option: MAGSCHED_PRIO0_EN gives requester 0 fixed top priority; its
// grants do not move the round-robin pointer, and requesters 1..NREQ-1 rotate.
// -----------------------------------------------------------------------------
module mag_sched
  import mag_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CMP_W-1:0] a_in,
  input  logic [NREQ*CMP_W-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  agb,
  output logic                  aeb,
  output logic                  alb,
  output logic                  busy
);

  localparam int WIDTH = CMP_W;
  localparam int RR_W  = idx_width(NREQ);

  logic [RR_W-1:0]  rr;
  logic             vld_p1;
  logic [RR_W-1:0]  own_p1;
  logic [WIDTH-1:0] op_a_p1;
  logic [WIDTH-1:0] op_b_p1;
  cmp_res_t         res_p2;

  logic [NREQ-1:0]  inflight;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  win_oh;
  logic [RR_W-1:0]  win_idx;
  logic             win_any;
  logic             rr_adv;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             c_gt, c_eq, c_lt;

  // ---- stage 0: arbitration ----
  always_comb begin
    inflight = '0;
    if (vld_p1) inflight[own_p1] = 1'b1;
    elig = req & ~inflight;
  end

`ifdef MAGSCHED_PRIO0_EN
  logic [NREQ-1:0] rr_elig;
  logic [NREQ-1:0] rr_oh;
  logic [RR_W-1:0] rr_idx;
  logic            rr_any;

  always_comb begin
    rr_elig    = elig;
    rr_elig[0] = 1'b0;
  end

  mag_rr_pick #(.NREQ(NREQ), .RR_W(RR_W)) u_pick (
    .elig    (rr_elig),
    .rr      (rr),
    .win_oh  (rr_oh),
    .win_idx (rr_idx),
    .win_any (rr_any)
  );

  always_comb begin
    win_oh  = rr_oh;
    win_idx = rr_idx;
    win_any = rr_any;
    rr_adv  = rr_any;
    if (elig[0]) begin
      win_oh    = '0;
      win_oh[0] = 1'b1;
      win_idx   = '0;
      win_any   = 1'b1;
      rr_adv    = 1'b0;
    end
  end
`else
  mag_rr_pick #(.NREQ(NREQ), .RR_W(RR_W)) u_pick (
    .elig    (elig),
    .rr      (rr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign rr_adv = win_any;
`endif

  // No grant is issued while reset is held, so nothing is lost on the edge.
  assign gnt = reset ? '0 : win_oh;

  // Operand mux with constant part-select bases.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == RR_W'(i)) begin
        sel_a = a_in[i*WIDTH +: WIDTH];
        sel_b = b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // ---- stage 1: captured operands feed the comparator ----
  mag_cmp12 u_cmp (
    .a   (op_a_p1),
    .b   (op_b_p1),
    .agb (c_gt),
    .aeb (c_eq),
    .alb (c_lt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      rr      <= '0;
      vld_p1  <= 1'b0;
      own_p1  <= '0;
      op_a_p1 <= '0;
      op_b_p1 <= '0;
      ack     <= '0;
      res_p2  <= CMP_RST;
    end else begin
      vld_p1 <= win_any;
      if (win_any) begin
        own_p1  <= win_idx;
        op_a_p1 <= sel_a;
        op_b_p1 <= sel_b;
      end
      if (rr_adv) begin
        rr <= (win_idx == RR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
      // ---- stage 2: registered result and ack pulse ----
      ack <= '0;
      if (vld_p1) begin
        ack[own_p1] <= 1'b1;
        res_p2      <= {c_gt, c_eq, c_lt};
      end
    end
  end

  assign agb  = res_p2[2];
  assign aeb  = res_p2[1];
  assign alb  = res_p2[0];
  assign busy = vld_p1 | (|ack);

endmodule

// File: tb/tb_mag_sched.sv
module tb_mag_sched;

  localparam int NREQ = 4;
  localparam int W    = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic              agb, aeb, alb, busy;

  always #5 clk = ~clk;

  mag_sched #(.NREQ(NREQ)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .a_in  (a_in),
    .b_in  (b_in),
    .gnt   (gnt),
    .ack   (ack),
    .agb   (agb),
    .aeb   (aeb),
    .alb   (alb),
    .busy  (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_s1: requester granted in the previous cycle (compare under way), -1 none
  // m_s2: requester whose ack is expected in the current cycle, -1 none
  int       m_rr  = 0;
  int       m_s1  = -1;
  int       m_s2  = -1;
  logic [2:0] m_s1_res = 3'b010;
  logic [2:0] m_out    = 3'b010;
  int       m_g   = -1;

  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a > b) return 3'b100;
    if (a == b) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [W-1:0] lane(input logic [NREQ*W-1:0] v, input int i);
    return W'(v >> (i*W));
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] e;
    int idx;
    e = r;
    for (int i = 0; i < NREQ; i++) if (i == m_s1) e = e & ~(NREQ'(1) << i);
`ifdef MAGSCHED_PRIO0_EN
    if (e[0]) return 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
      if (idx != 0 && ((e >> idx) & 1) != 0) return idx;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
      if (((e >> idx) & 1) != 0) return idx;
    end
`endif
    return -1;
  endfunction

  // Wait for the sample point of the current cycle and compare against model.
  task automatic sample();
    logic [NREQ-1:0] eg, ea;
    @(negedge clk);
    m_g = reset ? -1 : ref_pick(req);
    eg  = (m_g >= 0) ? (NREQ'(1) << m_g) : '0;
    ea  = (m_s2 >= 0) ? (NREQ'(1) << m_s2) : '0;
    chk("model_gnt",  32'(gnt), 32'(eg));
    chk("model_ack",  32'(ack), 32'(ea));
    chk("model_res",  32'({agb, aeb, alb}), 32'(m_out));
    chk("model_busy", 32'(busy), 32'((m_s1 >= 0) || (m_s2 >= 0)));
  endtask

  // Advance the model over the coming edge and move to the next cycle.
  task automatic commit();
    if (reset) begin
      m_rr = 0; m_s1 = -1; m_s2 = -1; m_out = 3'b010;
    end else begin
      m_s2 = m_s1;
      if (m_s1 >= 0) m_out = m_s1_res;
      if (m_g >= 0) begin
        m_s1_res = ref_cmp(lane(a_in, m_g), lane(b_in, m_g));
`ifdef MAGSCHED_PRIO0_EN
        if (m_g != 0) m_rr = (m_g + 1) % NREQ;
`else
        m_rr = (m_g + 1) % NREQ;
`endif
      end
      m_s1 = m_g;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < W; k++) begin
      a_in[i*W + k] = a[k];
      b_in[i*W + k] = b[k];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample();
    commit();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic [2:0]      res;
  } vec_t;

  vec_t tbl[8];
  logic prev0;

  initial begin
    reset = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    @(posedge clk);
    #1;

    // ---- reset values ----
    do_reset();
    sample();
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_res", 32'({agb, aeb, alb}), 32'(3'b010));
    chk("rst_busy", 32'(busy), 32'(0));
    commit();

    // ---- single request ----
    set_op(0, 12'h800, 12'h7FF);
    req = 4'b0001;
    sample();
    chk("single_gnt", 32'(gnt), 32'(4'b0001));
    commit();
    req = 4'b0000;
    sample();
    chk("single_busy", 32'(busy), 32'(1));
    commit();
    sample();
    chk("single_ack", 32'(ack), 32'(4'b0001));
    chk("single_res", 32'({agb, aeb, alb}), 32'(3'b100));
    commit();

    // ---- all four requesting from reset ----
    do_reset();
    set_op(0, 12'h123, 12'h123);
    set_op(1, 12'h000, 12'hFFF);
    set_op(2, 12'hFFF, 12'h000);
    set_op(3, 12'hA5A, 12'hA5B);
    tbl[0] = '{4'b1111, 4'b0001, 4'b0000, 3'b010};
    tbl[1] = '{4'b1110, 4'b0010, 4'b0000, 3'b010};
    tbl[2] = '{4'b1100, 4'b0100, 4'b0001, 3'b010};
    tbl[3] = '{4'b1000, 4'b1000, 4'b0010, 3'b001};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0100, 3'b100};
    tbl[5] = '{4'b0000, 4'b0000, 4'b1000, 3'b001};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 3'b001};
    tbl[7] = '{4'b1111, 4'b0001, 4'b0000, 3'b001};
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      sample();
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_res", i), 32'({agb, aeb, alb}), 32'(tbl[i].res));
      commit();
    end
    req = '0;
    for (int i = 0; i < 3; i++) begin sample(); commit(); end

    // ---- req0 and req1 held: strict alternation ----
    do_reset();
    set_op(0, 12'h900, 12'h100);
    set_op(1, 12'hF00, 12'h0FF);
    req   = 4'b0011;
    prev0 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sample();
      chk($sformatf("alt%0d_gnt", k), 32'(gnt), 32'((k % 2 == 0) ? 4'b0001 : 4'b0010));
      chk($sformatf("alt%0d_b2b", k), 32'(prev0 & gnt[0]), 32'(0));
      prev0 = gnt[0];
      commit();
    end
    req = '0;
    for (int i = 0; i < 3; i++) begin sample(); commit(); end

    // ---- reset in the cycle after a grant discards the compare ----
    set_op(2, 12'hFFF, 12'h000);
    req = 4'b0100;
    sample();
    chk("rmid_gnt", 32'(gnt), 32'(4'b0100));
    commit();
    req   = '0;
    reset = 1'b1;
    sample();
    commit();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample();
      chk($sformatf("rmid%0d_ack", k), 32'(ack), 32'(0));
      chk($sformatf("rmid%0d_res", k), 32'({agb, aeb, alb}), 32'(3'b010));
      chk($sformatf("rmid%0d_busy", k), 32'(busy), 32'(0));
      commit();
    end

    // ---- operands change after the grant ----
    set_op(2, 12'h400, 12'h200);
    req = 4'b0100;
    sample();
    chk("opchg_gnt", 32'(gnt), 32'(4'b0100));
    commit();
    set_op(2, 12'h001, 12'h200);
    req = '0;
    sample();
    commit();
    sample();
    chk("opchg_ack", 32'(ack), 32'(4'b0100));
    chk("opchg_res", 32'({agb, aeb, alb}), 32'(3'b100));
    commit();

`ifdef MAGSCHED_PRIO0_EN
    // ---- fixed priority for requester 0, rotation among the rest ----
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      logic [NREQ-1:0] pe;
      case (k)
        1, 7:    pe = 4'b0010;
        3:       pe = 4'b0100;
        5:       pe = 4'b1000;
        default: pe = 4'b0001;
      endcase
      sample();
      chk($sformatf("prio%0d_gnt", k), 32'(gnt), 32'(pe));
      commit();
    end
    req = '0;
    for (int i = 0; i < 3; i++) begin sample(); commit(); end
`endif

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      req   = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        logic [W-1:0] ra, rb;
        ra = W'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
        set_op(i, ra, rb);
      end
      sample();
      commit();
    end
    reset = 1'b0;
    req   = '0;
    for (int i = 0; i < 3; i++) begin sample(); commit(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
